core_bus_arbiter: RTL and testbench
===================================

// Module: core_bus_arbiter
// PURPOSE
//  Arbitrates one shared memory bus between instruction fetch (IF) and the
//  execute-stage data port (EX load/store). Keeps one transaction outstanding
//  and sequences it with a req/ack handshake. Raises hold_flag_out to core_ctrl
//  while an EX access is pending, so the pipeline stalls for multi-cycle memory.
// PARAMETERS
//  ADDR_W      32  bus address width
//  DATA_W      32  bus data width
//  STARVE_MAX  4   EX grants in a row, with IF waiting, before IF is forced next
//  TIMEOUT     16  cycles without ack before abort (only with BUS_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, asynchronous, active-high
//  ex_req_in      in   1       EX access request, held until ex_ready_out
//  ex_we_in       in   1       1=write, 0=read
//  ex_addr_in     in   ADDR_W  EX word-aligned address
//  ex_wdata_in    in   DATA_W  EX write data (pre-merged SB/SH word)
//  ex_rdata_out   out  DATA_W  EX read data, valid with ex_ready_out
//  ex_ready_out   out  1       1-cycle pulse: EX access complete
//  if_req_in      in   1       fetch request, held until if_ready_out
//  if_addr_in     in   ADDR_W  fetch address
//  if_rdata_out   out  DATA_W  fetched instruction, valid with if_ready_out
//  if_ready_out   out  1       1-cycle pulse: fetch complete
//  hold_flag_out  out  1       stall request to core_ctrl
//  bus_req_out    out  1       bus request
//  bus_we_out     out  1       bus write enable
//  bus_addr_out   out  ADDR_W  bus address
//  bus_wdata_out  out  DATA_W  bus write data
//  bus_rdata_in   in   DATA_W  bus read data, valid with bus_ack_in
//  bus_ack_in     in   1       bus completion, 1 cycle
//  bus_err_out    out  1       sticky timeout flag (BUS_TIMEOUT_EN only)
// BEHAVIOUR
//  - FSM states: IDLE, GNT_EX, GNT_IF. All outputs are registered.
//  - Reset (async): state=IDLE. bus_req/we, ready pulses, and hold_flag go to 0.
//    Addr, wdata, rdata, starve count, and err are cleared to 0.
//  - IDLE: decides on current inputs. EX wins if ex_req_in, unless if_req_in and
//    starve_cnt==STARVE_MAX, in which case IF wins. Otherwise IF if if_req_in.
//    The winner's addr/we/wdata are latched. bus_req_out=1 from the next cycle.
//  - IF grant: bus_we_out=0, bus_wdata_out=0.
//  - GNT_x: addr/we/wdata/req stay stable until bus_ack_in. Inputs are not
//    re-sampled. On the ack edge: rdata latched into x_rdata_out,
//    x_ready_out=1 for exactly 1 cycle, bus_req_out=0, state->IDLE.
//  - Latency: request seen at cycle N -> bus_req_out at N+1. Ack at M ->
//    ready/rdata at M+1. Minimum 3 cycles per access. Back-to-back accesses
//    re-arbitrate in IDLE.
//  - x_rdata_out holds its value until the next ack for the same port.
//    Write acks leave ex_rdata_out unchanged.
//  - starve_cnt: +1 (saturates at STARVE_MAX) on each EX grant while
//    if_req_in=1. Cleared on IF grant or when if_req_in=0 in IDLE.
//  - hold_flag_out=1 in any cycle where ex_req_in=1 and ex_ready_out=0.
//    Combinational on ex_req_in, registered on the ready pulse.
//  - bus_ack_in in IDLE is ignored.
//  - If a requester drops its req mid-grant, the access still completes and
//    ready pulses. Requesters must not do this; it is a protocol violation.
//  - Async reset mid-grant aborts immediately. No ready pulse is issued, and
//    a late ack after reset is ignored.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: a counter runs in GNT_x. TIMEOUT cycles without
//    ack -> abort: x_rdata_out=0, x_ready_out pulses, bus_req_out=0,
//    bus_err_out=1 (sticky until rst), state->IDLE.
//  BUS_TIMEOUT_EN undefined: the arbiter waits for ack indefinitely.
//    bus_err_out is tied to 0 and the counter is not built.
// TESTING
//  1 Reset then idle: all outputs 0. No bus_req_out with both reqs low.
//  2 IF read @0x100, ack 2 cycles later with 0x00A00093:
//    if_ready_out pulses once, if_rdata_out=0x00A00093, bus_we_out=0.
//  3 EX and IF requests in the same IDLE cycle: EX (@0x2000 write 0xDEADBEEF)
//    granted first; hold_flag_out=1 until ex_ready_out; IF is granted next.
//  4 EX held continuously with IF waiting, STARVE_MAX=4: grant order is
//    EX,EX,EX,EX,IF,EX...
//  5 rst asserted mid-GNT_EX, then a stray ack: bus_req_out=0 immediately,
//    no ready pulse, state IDLE.
//  6 BUS_TIMEOUT_EN, no ack for 16 cycles: ex_ready_out pulses,
//    ex_rdata_out=0, bus_err_out=1 and stays 1.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// Shares one memory bus between instruction fetch (IF) and the EX data port, with one access in flight.
// Define BUS_TIMEOUT_EN to build the ack watchdog that aborts stuck accesses and sets bus_err_out.
module core_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_req_in,
    input  logic              ex_we_in,
    input  logic [ADDR_W-1:0] ex_addr_in,
    input  logic [DATA_W-1:0] ex_wdata_in,
    output logic [DATA_W-1:0] ex_rdata_out,
    output logic              ex_ready_out,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic [DATA_W-1:0] if_rdata_out,
    output logic              if_ready_out,
    output logic              hold_flag_out,
    output logic              bus_req_out,
    output logic              bus_we_out,
    output logic [ADDR_W-1:0] bus_addr_out,
    output logic [DATA_W-1:0] bus_wdata_out,
    input  logic [DATA_W-1:0] bus_rdata_in,
    input  logic              bus_ack_in,
    output logic              bus_err_out
);

    typedef enum logic [1:0] {IDLE, GNT_EX, GNT_IF} state_t;

    localparam int SW = $clog2(STARVE_MAX + 1);

    if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_param_check
        $error("core_bus_arbiter: STARVE_MAX and TIMEOUT must be at least 1");
    end

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          arb_ok;
    logic          pick_ex;
    logic          pick_if;
    logic          ack_done;
    logic          abort;

    // The ready-pulse cycle is skipped for arbitration: the finished requester
    // still shows its old request then and must not be granted twice.
    assign arb_ok   = (state == IDLE) && !ex_ready_out && !if_ready_out;
    assign pick_ex  = arb_ok && ex_req_in && !(if_req_in && starve_cnt == SW'(STARVE_MAX));
    assign pick_if  = arb_ok && if_req_in && !pick_ex;
    assign ack_done = (state != IDLE) && bus_ack_in;

    assign hold_flag_out = ex_req_in && !ex_ready_out && !rst;

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;

    assign abort = (state != IDLE) && !bus_ack_in && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt     <= '0;
            bus_err_out <= 1'b0;
        end else begin
            if (state == IDLE || bus_ack_in) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (abort) begin
                bus_err_out <= 1'b1;
            end
        end
    end
`else
    assign abort       = 1'b0;
    assign bus_err_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_ex) begin
                    state_nxt = GNT_EX;
                end else if (pick_if) begin
                    state_nxt = GNT_IF;
                end
            end
            GNT_EX, GNT_IF: begin
                if (ack_done || abort) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_out   <= 1'b0;
            bus_we_out    <= 1'b0;
            bus_addr_out  <= '0;
            bus_wdata_out <= '0;
            ex_rdata_out  <= '0;
            if_rdata_out  <= '0;
            ex_ready_out  <= 1'b0;
            if_ready_out  <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            ex_ready_out <= 1'b0;
            if_ready_out <= 1'b0;

            if (pick_ex) begin
                bus_req_out   <= 1'b1;
                bus_we_out    <= ex_we_in;
                bus_addr_out  <= ex_addr_in;
                bus_wdata_out <= ex_wdata_in;
            end else if (pick_if) begin
                bus_req_out   <= 1'b1;
                bus_we_out    <= 1'b0;
                bus_addr_out  <= if_addr_in;
                bus_wdata_out <= '0;
            end

            if (ack_done || abort) begin
                bus_req_out <= 1'b0;
                if (state == GNT_EX) begin
                    ex_ready_out <= 1'b1;
                    if (abort) begin
                        ex_rdata_out <= '0;
                    end else if (!bus_we_out) begin
                        ex_rdata_out <= bus_rdata_in;
                    end
                end else begin
                    if_ready_out <= 1'b1;
                    if_rdata_out <= abort ? '0 : bus_rdata_in;
                end
            end

            // Count consecutive EX wins that left a fetch waiting.
            if (pick_if) begin
                starve_cnt <= '0;
            end else if (pick_ex && if_req_in) begin
                if (starve_cnt != SW'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (state == IDLE && !if_req_in) begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: cycle vector table, directed corner sequences, then random traffic against a reference model.
module tb_core_bus_arbiter;

    localparam int          STARVE_MAX = 4;
    localparam int          TIMEOUT    = 16;
    localparam logic        L   = 1'b0;
    localparam logic        H   = 1'b1;
    localparam logic [31:0] Z   = 32'h0;
    localparam logic [31:0] EXA = 32'h0000_2000;
    localparam logic [31:0] IFA = 32'h0000_0100;
    localparam logic [31:0] EXW = 32'hDEAD_BEEF;
    localparam logic [31:0] INS = 32'h00A0_0093;
    localparam logic [31:0] CAF = 32'hCAFE_F00D;
    localparam logic [31:0] RDX = 32'h55AA_55AA;

    logic        clk;
    logic        rst;
    logic        ex_req;
    logic        ex_we;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [31:0] ex_rdata;
    logic        ex_ready;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        hold;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    core_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_req_in(ex_req), .ex_we_in(ex_we), .ex_addr_in(ex_addr), .ex_wdata_in(ex_wdata),
        .ex_rdata_out(ex_rdata), .ex_ready_out(ex_ready),
        .if_req_in(if_req), .if_addr_in(if_addr), .if_rdata_out(if_rdata), .if_ready_out(if_ready),
        .hold_flag_out(hold),
        .bus_req_out(bus_req), .bus_we_out(bus_we), .bus_addr_out(bus_addr), .bus_wdata_out(bus_wdata),
        .bus_rdata_in(bus_rdata), .bus_ack_in(bus_ack), .bus_err_out(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        exq, we, ifq, ack;
        logic [31:0] rd;
        logic        oreq, owe;
        logic [31:0] oaddr, owd;
        logic        oexr, oifr, ohold;
        logic [31:0] oexd, oifd;
    } vec_t;

    vec_t tv[21];

    function automatic vec_t v(input logic exq, input logic we, input logic ifq, input logic ack,
                               input logic [31:0] rd, input logic oreq, input logic owe,
                               input logic [31:0] oaddr, input logic [31:0] owd, input logic oexr,
                               input logic oifr, input logic ohold, input logic [31:0] oexd,
                               input logic [31:0] oifd);
        return '{exq, we, ifq, ack, rd, oreq, owe, oaddr, owd, oexr, oifr, ohold, oexd, oifd};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bus_req"}, 32'(bus_req), Z);
        chk({tag, "_bus_we"}, 32'(bus_we), Z);
        chk({tag, "_bus_addr"}, bus_addr, Z);
        chk({tag, "_bus_wdata"}, bus_wdata, Z);
        chk({tag, "_ex_ready"}, 32'(ex_ready), Z);
        chk({tag, "_if_ready"}, 32'(if_ready), Z);
        chk({tag, "_ex_rdata"}, ex_rdata, Z);
        chk({tag, "_if_rdata"}, if_rdata, Z);
        chk({tag, "_hold"}, 32'(hold), Z);
        chk({tag, "_bus_err"}, 32'(bus_err), Z);
    endtask

    task automatic clear_inputs();
        ex_req = 0; ex_we = 0; ex_addr = Z; ex_wdata = Z;
        if_req = 0; if_addr = Z; bus_ack = 0; bus_rdata = Z;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        chk_zero("rst");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Finish any access in flight with an immediate ack, requests withdrawn.
    task automatic drain();
        @(posedge clk); #1;
        ex_req = 0; if_req = 0;
        for (int c = 0; c < 6; c++) begin
            bus_ack = bus_req;
            @(posedge clk); #1;
        end
        bus_ack = 0;
    endtask

    // Reference model: which port owns the bus, the per-port results and the
    // fetch-starvation tally, advanced once per clock from the sampled inputs.
    int          m_owner;
    int          m_starve;
    logic        m_req, m_we, m_exr, m_ifr;
    logic [31:0] m_addr, m_wd, m_exd, m_ifd;

    task automatic model_step();
        logic nexr, nifr;
        nexr = 1'b0;
        nifr = 1'b0;
        if (m_owner != 0) begin
            if (bus_ack) begin
                if (m_owner == 1) begin
                    nexr = 1'b1;
                    if (!m_we) m_exd = bus_rdata;
                end else begin
                    nifr = 1'b1;
                    m_ifd = bus_rdata;
                end
                m_owner = 0;
                m_req   = 1'b0;
            end
        end else if (!m_exr && !m_ifr && (ex_req || if_req)) begin
            if (ex_req && !(if_req && m_starve == STARVE_MAX)) begin
                m_owner = 1; m_we = ex_we; m_addr = ex_addr; m_wd = ex_wdata;
                m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
            end else begin
                m_owner = 2; m_we = 1'b0; m_addr = if_addr; m_wd = Z;
                m_starve = 0;
            end
            m_req = 1'b1;
        end else if (!if_req) begin
            m_starve = 0;
        end
        m_exr = nexr;
        m_ifr = nifr;
    endtask

    initial begin
        logic [31:0] order[6];
        logic [31:0] exp_order[6];
        int          ng;
        int          cnt;
        logic        prev;
        int          wait_c;

        rst = 1'b0;
        clear_inputs();
        #2 rst = 1'b1;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single IF read, EX+IF collision, stray idle ack, EX read at minimum latency.
        tv[0]  = v(L,L,L,L,Z,            L,L,Z,  Z,  L,L,L,Z,  Z);
        tv[1]  = v(L,L,L,L,Z,            L,L,Z,  Z,  L,L,L,Z,  Z);
        tv[2]  = v(L,L,H,L,Z,            L,L,Z,  Z,  L,L,L,Z,  Z);
        tv[3]  = v(L,L,H,L,Z,            H,L,IFA,Z,  L,L,L,Z,  Z);
        tv[4]  = v(L,L,H,H,INS,          H,L,IFA,Z,  L,L,L,Z,  Z);
        tv[5]  = v(L,L,H,L,Z,            L,L,IFA,Z,  L,H,L,Z,  INS);
        tv[6]  = v(L,L,L,L,Z,            L,L,IFA,Z,  L,L,L,Z,  INS);
        tv[7]  = v(H,H,H,L,Z,            L,L,IFA,Z,  L,L,H,Z,  INS);
        tv[8]  = v(H,H,H,L,Z,            H,H,EXA,EXW,L,L,H,Z,  INS);
        tv[9]  = v(H,H,H,H,32'h12345678, H,H,EXA,EXW,L,L,H,Z,  INS);
        tv[10] = v(H,H,H,L,Z,            L,H,EXA,EXW,H,L,L,Z,  INS);
        tv[11] = v(L,L,H,L,Z,            L,H,EXA,EXW,L,L,L,Z,  INS);
        tv[12] = v(L,L,H,L,Z,            H,L,IFA,Z,  L,L,L,Z,  INS);
        tv[13] = v(L,L,H,H,CAF,          H,L,IFA,Z,  L,L,L,Z,  INS);
        tv[14] = v(L,L,H,L,Z,            L,L,IFA,Z,  L,H,L,Z,  CAF);
        tv[15] = v(L,L,L,H,32'hBAD0BAD0, L,L,IFA,Z,  L,L,L,Z,  CAF);
        tv[16] = v(L,L,L,L,Z,            L,L,IFA,Z,  L,L,L,Z,  CAF);
        tv[17] = v(H,L,L,L,Z,            L,L,IFA,Z,  L,L,H,Z,  CAF);
        tv[18] = v(H,L,L,H,RDX,          H,L,EXA,EXW,L,L,H,Z,  CAF);
        tv[19] = v(H,L,L,L,Z,            L,L,EXA,EXW,H,L,L,RDX,CAF);
        tv[20] = v(L,L,L,L,Z,            L,L,EXA,EXW,L,L,L,RDX,CAF);

        ex_addr = EXA; ex_wdata = EXW; if_addr = IFA;
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            ex_req = tv[i].exq; ex_we = tv[i].we; if_req = tv[i].ifq;
            bus_ack = tv[i].ack; bus_rdata = tv[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), 32'(bus_req), 32'(tv[i].oreq));
            chk($sformatf("vec%0d_we", i), 32'(bus_we), 32'(tv[i].owe));
            chk($sformatf("vec%0d_addr", i), bus_addr, tv[i].oaddr);
            chk($sformatf("vec%0d_wdata", i), bus_wdata, tv[i].owd);
            chk($sformatf("vec%0d_ex_ready", i), 32'(ex_ready), 32'(tv[i].oexr));
            chk($sformatf("vec%0d_if_ready", i), 32'(if_ready), 32'(tv[i].oifr));
            chk($sformatf("vec%0d_hold", i), 32'(hold), 32'(tv[i].ohold));
            chk($sformatf("vec%0d_ex_rdata", i), ex_rdata, tv[i].oexd);
            chk($sformatf("vec%0d_if_rdata", i), if_rdata, tv[i].oifd);
        end

        // EX held continuously with fetch waiting: four EX grants, then IF.
        exp_order[0] = EXA; exp_order[1] = EXA; exp_order[2] = EXA;
        exp_order[3] = EXA; exp_order[4] = IFA; exp_order[5] = EXA;
        @(posedge clk); #1;
        ex_req = 1; ex_we = 1; if_req = 1; bus_ack = 0;
        ng = 0;
        prev = 1'b0;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            @(negedge clk);
            if (bus_req && !prev) begin
                order[ng] = bus_addr;
                ng++;
            end
            prev = bus_req;
            @(posedge clk); #1;
            bus_ack = bus_req;
        end
        chk("starve_grant_count", 32'(ng), 32'd6);
        for (int i = 0; i < ng; i++) chk($sformatf("starve_grant%0d", i), order[i], exp_order[i]);
        drain();

`ifdef BUS_TIMEOUT_EN
        @(posedge clk); #1;
        ex_req = 1; ex_we = 0; ex_addr = 32'h0000_3000; bus_ack = 0;
        cnt  = 0;
        prev = 1'b0;
        for (int c = 0; c < 40 && !prev; c++) begin
            @(negedge clk);
            if (ex_ready) prev = 1'b1;
            else if (bus_req) cnt++;
        end
        chk("tmo_ready_seen", 32'(prev), 32'd1);
        chk("tmo_wait_cycles", 32'(cnt), 32'(TIMEOUT));
        chk("tmo_ex_rdata", ex_rdata, Z);
        chk("tmo_err", 32'(bus_err), 32'd1);
        @(posedge clk); #1;
        ex_req = 0;
        repeat (3) @(negedge clk);
        chk("tmo_err_sticky", 32'(bus_err), 32'd1);
        chk("tmo_req_dropped", 32'(bus_req), Z);
`else
        @(posedge clk); #1;
        ex_req = 1; ex_we = 0; ex_addr = 32'h0000_3000; bus_ack = 0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ex_ready) cnt++;
        end
        chk("noack_req_held", 32'(bus_req), 32'd1);
        chk("noack_no_ready", 32'(cnt), Z);
        chk("noack_err", 32'(bus_err), Z);
        chk("noack_hold", 32'(hold), 32'd1);
`endif
        drain();
        repeat (3) @(posedge clk);

        // Reset in the middle of an EX grant, followed by a late ack.
        #1;
        ex_req = 1; ex_we = 0; ex_addr = EXA; bus_ack = 0;
        @(posedge clk); #1;
        chk("rstmid_granted", 32'(bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_req", 32'(bus_req), Z);
        chk("rstmid_hold", 32'(hold), Z);
        chk("rstmid_ready", 32'(ex_ready), Z);
        @(posedge clk); #1;
        rst = 1'b0; ex_req = 0; bus_ack = 1; bus_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("rstmid_late_ready", 32'(ex_ready), Z);
        @(posedge clk); #1;
        bus_ack = 0;
        @(negedge clk);
        chk("rstmid_late_ready2", 32'(ex_ready), Z);
        chk("rstmid_rdata", ex_rdata, Z);
        chk("rstmid_idle_req", 32'(bus_req), Z);
        @(posedge clk); #1;
        if_req = 1; if_addr = IFA;
        @(posedge clk); #1;
        chk("rstmid_regrant", 32'(bus_req), 32'd1);
        chk("rstmid_regrant_addr", bus_addr, IFA);
        drain();

        // Randomised traffic against the model, starting from reset.
        do_reset();
        m_owner = 0; m_starve = 0;
        m_req = 0; m_we = 0; m_exr = 0; m_ifr = 0;
        m_addr = Z; m_wd = Z; m_exd = Z; m_ifd = Z;
        prev   = 1'b0;
        wait_c = 0;
        for (int cyc = 0; cyc < 1500 && errors < 40; cyc++) begin
            @(posedge clk); #1;
            if (ex_req && ex_ready) ex_req = 0;
            if (!ex_req && $urandom_range(0, 2) == 0) begin
                ex_req = 1; ex_we = 1'($urandom_range(0, 1));
                ex_addr = $urandom & ~32'h3; ex_wdata = $urandom;
            end
            if (if_req && if_ready) if_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom & ~32'h3;
            end
            bus_rdata = $urandom;
            if (bus_req) begin
                if (!prev) wait_c = $urandom_range(0, 3);
                bus_ack = (wait_c == 0);
                if (wait_c > 0) wait_c--;
            end else begin
                bus_ack = ($urandom_range(0, 7) == 0);
            end
            prev = bus_req;
            @(negedge clk);
            chk("rnd_req", 32'(bus_req), 32'(m_req));
            chk("rnd_we", 32'(bus_we), 32'(m_we));
            chk("rnd_addr", bus_addr, m_addr);
            chk("rnd_wdata", bus_wdata, m_wd);
            chk("rnd_ex_ready", 32'(ex_ready), 32'(m_exr));
            chk("rnd_if_ready", 32'(if_ready), 32'(m_ifr));
            chk("rnd_ex_rdata", ex_rdata, m_exd);
            chk("rnd_if_rdata", if_rdata, m_ifd);
            chk("rnd_hold", 32'(hold), 32'(ex_req && !m_exr));
            chk("rnd_err", 32'(bus_err), Z);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
